// File: rtl/talco_tile_loader.sv
// talco_tile_loader: feeds ref/query tiles from sequence memory into the TALCO-XDrop aligner BRAMs; define TALCO_LOADER_PERF_EN for cycle counters
module talco_tile_loader #(
    parameter int CHAR_WIDTH      = 8,
    parameter int WORD_WIDTH      = 32,
    parameter int CPW             = WORD_WIDTH / CHAR_WIDTH,
    parameter int MAX_TILE_SIZE   = 512,
    parameter int LEN_WIDTH       = 16,
    parameter int MEM_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TILE_ADDR_WIDTH = $clog2(MAX_TILE_SIZE / CPW)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]         cfg_ref_base,
    input  logic [MEM_ADDR_WIDTH-1:0]         cfg_query_base,
    input  logic [LEN_WIDTH-1:0]              cfg_ref_len,
    input  logic [LEN_WIDTH-1:0]              cfg_query_len,
    input  logic [$clog2(MAX_TILE_SIZE):0]    cfg_marker,
    input  logic [1:0]                        cfg_init_state,
    output logic                              mem_rd_req,
    input  logic                              mem_rd_ready,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic                              mem_rd_valid,
    input  logic [WORD_WIDTH-1:0]             mem_rd_data,
    output logic                              ref_wr_en,
    output logic                              query_wr_en,
    output logic [TILE_ADDR_WIDTH-1:0]        ref_addr_in,
    output logic [TILE_ADDR_WIDTH-1:0]        query_addr_in,
    output logic [WORD_WIDTH-1:0]             ref_bram_data_in,
    output logic [WORD_WIDTH-1:0]             query_bram_data_in,
    output logic [$clog2(CPW)-1:0]            ref_start_offset,
    output logic [$clog2(CPW)-1:0]            query_start_offset,
    output logic [1:0]                        init_state,
    output logic                              start,
    output logic                              tile_rst,
    input  logic                              stop,
    input  logic [LEN_WIDTH-1:0]              ref_next_tile_addr,
    input  logic [LEN_WIDTH-1:0]              query_next_tile_addr,
    input  logic [1:0]                        next_tile_init_state,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [LEN_WIDTH-1:0]              tile_count
`ifdef TALCO_LOADER_PERF_EN
    ,
    output logic [31:0]                       perf_load_cycles,
    output logic [31:0]                       perf_align_cycles
`endif
);
    localparam int LCPW = $clog2(CPW);
    localparam int MW   = $clog2(MAX_TILE_SIZE) + 1;
    localparam int WCW  = TILE_ADDR_WIDTH + 1;
    localparam int PW   = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

    typedef logic [LEN_WIDTH:0]         wlen_t;
    typedef logic [MEM_ADDR_WIDTH-1:0]  addr_t;
    typedef logic [PW:0]                cnt_t;
    typedef logic [MW-1:0]              mk_t;
    typedef logic [TILE_ADDR_WIDTH:0]   tag_t;
    typedef enum logic [2:0] {IDLE, LOAD, START, RST, ADVANCE, DONE} state_t;

    state_t             state;
    addr_t              base_r, base_q;
    logic [LEN_WIDTH-1:0] len_r, len_q, pos_r, pos_q, nta_r, nta_q;
    mk_t                marker;
    logic [1:0]         nis;
    logic [WCW-1:0]     iss_r, iss_q;
    logic               turn;
    cnt_t               cnt;
    logic [PW-1:0]      wp, rp;
    tag_t               fifo [MAX_OUTSTANDING];

    wlen_t          widx_r, widx_q, need_r, need_q, rem_r, rem_q, np_r, np_q;
    logic [WCW-1:0] nw_r, nw_q;
    logic           left_r, left_q, ch, acc, pop, cfg_bad;
    tag_t           head;

    // Words still to fetch per channel: tile span clipped to the end of the sequence
    assign widx_r  = wlen_t'(pos_r) >> LCPW;
    assign widx_q  = wlen_t'(pos_q) >> LCPW;
    assign need_r  = (wlen_t'(pos_r[LCPW-1:0]) + wlen_t'(marker) + wlen_t'(CPW - 1)) >> LCPW;
    assign need_q  = (wlen_t'(pos_q[LCPW-1:0]) + wlen_t'(marker) + wlen_t'(CPW - 1)) >> LCPW;
    assign rem_r   = ((wlen_t'(len_r) + wlen_t'(CPW - 1)) >> LCPW) - widx_r;
    assign rem_q   = ((wlen_t'(len_q) + wlen_t'(CPW - 1)) >> LCPW) - widx_q;
    assign nw_r    = need_r < rem_r ? need_r[WCW-1:0] : rem_r[WCW-1:0];
    assign nw_q    = need_q < rem_q ? need_q[WCW-1:0] : rem_q[WCW-1:0];
    assign left_r  = iss_r != nw_r;
    assign left_q  = iss_q != nw_q;
    assign ch      = left_r && left_q ? turn : !left_r;
    assign np_r    = wlen_t'(pos_r) + wlen_t'(nta_r);
    assign np_q    = wlen_t'(pos_q) + wlen_t'(nta_q);
    assign cfg_bad = cfg_marker == '0 || cfg_marker > mk_t'(MAX_TILE_SIZE - CPW + 1);

    // Request side: held stable until accepted since only acceptance changes channel/count
    assign mem_rd_req  = state == LOAD && cnt < cnt_t'(MAX_OUTSTANDING) && (left_r || left_q);
    assign mem_rd_addr = !mem_rd_req ? '0 : ch ? base_q + addr_t'(widx_q) + addr_t'(iss_q)
                                               : base_r + addr_t'(widx_r) + addr_t'(iss_r);
    assign acc         = mem_rd_req && mem_rd_ready;

    // Response side: each in-order response is routed by the tag at the FIFO head
    assign head               = fifo[rp];
    assign pop                = mem_rd_valid && state == LOAD && cnt != '0;
    assign ref_wr_en          = pop && !head[TILE_ADDR_WIDTH];
    assign query_wr_en        = pop && head[TILE_ADDR_WIDTH];
    assign ref_addr_in        = ref_wr_en ? head[TILE_ADDR_WIDTH-1:0] : '0;
    assign query_addr_in      = query_wr_en ? head[TILE_ADDR_WIDTH-1:0] : '0;
    assign ref_bram_data_in   = ref_wr_en ? mem_rd_data : '0;
    assign query_bram_data_in = query_wr_en ? mem_rd_data : '0;

    // Tag storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (acc) fifo[wp] <= tag_t'({ch, ch ? iss_q[TILE_ADDR_WIDTH-1:0] : iss_r[TILE_ADDR_WIDTH-1:0]});
    end

    // Tag FIFO pointers and outstanding-read count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (acc) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + cnt_t'(acc) - cnt_t'(pop);
        end
    end

    // Job sequencing: config, load, align, tile reset, advance, done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cfg_ready          <= 1'b1;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            start              <= 1'b0;
            tile_rst           <= 1'b0;
            tile_count         <= '0;
            init_state         <= '0;
            ref_start_offset   <= '0;
            query_start_offset <= '0;
            base_r             <= '0;
            base_q             <= '0;
            len_r              <= '0;
            len_q              <= '0;
            marker             <= '0;
            pos_r              <= '0;
            pos_q              <= '0;
            nta_r              <= '0;
            nta_q              <= '0;
            nis                <= '0;
            iss_r              <= '0;
            iss_q              <= '0;
            turn               <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    if (cfg_bad) error <= 1'b1;
                    else begin
                        base_r             <= cfg_ref_base;
                        base_q             <= cfg_query_base;
                        len_r              <= cfg_ref_len;
                        len_q              <= cfg_query_len;
                        marker             <= cfg_marker;
                        init_state         <= cfg_init_state;
                        pos_r              <= '0;
                        pos_q              <= '0;
                        iss_r              <= '0;
                        iss_q              <= '0;
                        turn               <= 1'b0;
                        ref_start_offset   <= '0;
                        query_start_offset <= '0;
                        tile_count         <= '0;
                        busy               <= 1'b1;
                        cfg_ready          <= 1'b0;
                        if (cfg_ref_len == '0 || cfg_query_len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else state <= LOAD;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        if (ch) iss_q <= iss_q + 1'b1;
                        else iss_r <= iss_r + 1'b1;
                        turn <= !ch;
                    end
                    if (!left_r && !left_q && cnt == '0) begin
                        start <= 1'b1;
                        state <= START;
                    end
                end
                START: if (stop) begin
                    start      <= 1'b0;
                    tile_rst   <= 1'b1;
                    nta_r      <= ref_next_tile_addr;
                    nta_q      <= query_next_tile_addr;
                    nis        <= next_tile_init_state;
                    tile_count <= tile_count + 1'b1;
                    state      <= RST;
                end
                RST: begin
                    tile_rst <= 1'b0;
                    state    <= ADVANCE;
                end
                ADVANCE: begin
                    if (nta_r == '0 && nta_q == '0) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (np_r >= wlen_t'(len_r) || np_q >= wlen_t'(len_q)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        pos_r              <= np_r[LEN_WIDTH-1:0];
                        pos_q              <= np_q[LEN_WIDTH-1:0];
                        ref_start_offset   <= np_r[LCPW-1:0];
                        query_start_offset <= np_q[LCPW-1:0];
                        init_state         <= nis;
                        iss_r              <= '0;
                        iss_q              <= '0;
                        turn               <= 1'b0;
                        state              <= LOAD;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TALCO_LOADER_PERF_EN
    // Saturating per-job cycle counters for load and align phases
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_cycles  <= '0;
            perf_align_cycles <= '0;
        end else if (state == IDLE && cfg_valid && !cfg_bad) begin
            perf_load_cycles  <= '0;
            perf_align_cycles <= '0;
        end else begin
            if (state == LOAD && !(&perf_load_cycles)) perf_load_cycles <= perf_load_cycles + 1'b1;
            if (state == START && !(&perf_align_cycles)) perf_align_cycles <= perf_align_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_talco_tile_loader.sv
// tb_talco_tile_loader: directed bench with memory responder and BRAM shadow for talco_tile_loader
module tb_talco_tile_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_ref_base, cfg_query_base;
    logic [15:0] cfg_ref_len, cfg_query_len;
    logic [9:0]  cfg_marker;
    logic [1:0]  cfg_init_state;
    logic        mem_rd_req, mem_rd_ready, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        ref_wr_en, query_wr_en;
    logic [6:0]  ref_addr_in, query_addr_in;
    logic [31:0] ref_bram_data_in, query_bram_data_in;
    logic [1:0]  ref_start_offset, query_start_offset, init_state;
    logic        start, tile_rst, stop;
    logic [15:0] ref_next_tile_addr, query_next_tile_addr;
    logic [1:0]  next_tile_init_state;
    logic        busy, done, error;
    logic [15:0] tile_count;

    talco_tile_loader dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ref_base(cfg_ref_base), .cfg_query_base(cfg_query_base),
        .cfg_ref_len(cfg_ref_len), .cfg_query_len(cfg_query_len),
        .cfg_marker(cfg_marker), .cfg_init_state(cfg_init_state),
        .mem_rd_req(mem_rd_req), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .ref_wr_en(ref_wr_en), .query_wr_en(query_wr_en),
        .ref_addr_in(ref_addr_in), .query_addr_in(query_addr_in),
        .ref_bram_data_in(ref_bram_data_in), .query_bram_data_in(query_bram_data_in),
        .ref_start_offset(ref_start_offset), .query_start_offset(query_start_offset),
        .init_state(init_state), .start(start), .tile_rst(tile_rst), .stop(stop),
        .ref_next_tile_addr(ref_next_tile_addr), .query_next_tile_addr(query_next_tile_addr),
        .next_tile_init_state(next_tile_init_state),
        .busy(busy), .done(done), .error(error), .tile_count(tile_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    typedef struct {logic [31:0] addr; int due;} rq_t;
    rq_t         q[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    bit          rnd_ready = 0, req_seen = 0;
    logic [31:0] rb [0:127];
    logic [31:0] qb [0:127];
    int          nwr_r = 0, nwr_q = 0;

    // memory model: samples DUT at negedge, drives responses 1ns after posedge
    initial begin
        mem_rd_ready = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) q.delete();
            else begin
                if (ref_wr_en) begin rb[ref_addr_in] = ref_bram_data_in; nwr_r++; end
                if (query_wr_en) begin qb[query_addr_in] = query_bram_data_in; nwr_q++; end
                if (mem_rd_req) req_seen = 1;
                if (mem_rd_req && mem_rd_ready) begin
                    check("outstanding", 64'(q.size() + int'(mem_rd_valid) + 1 <= 4), 1);
                    q.push_back('{mem_rd_addr, cyc + int'($urandom_range(lat_min, lat_max)) - 1});
                end
            end
            @(posedge clk);
            #1;
            if (rst && q.size() > 0 && q[0].due <= cyc) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = memw(q[0].addr);
                void'(q.pop_front());
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data  = '0;
            end
            mem_rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic run_cfg(input logic [31:0] rbase, qbase, input logic [15:0] rl, ql,
                           input logic [9:0] mk, input logic [1:0] is);
        @(posedge clk);
        #1;
        cfg_ref_base = rbase; cfg_query_base = qbase;
        cfg_ref_len = rl; cfg_query_len = ql;
        cfg_marker = mk; cfg_init_state = is;
        cfg_valid = 1'b1;
        nwr_r = 0; nwr_q = 0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (start) return;
        end
        check({tag, "_start_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, output bit err);
        err = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (error) err = 1;
            if (done) return;
        end
        check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic check_tile(input string tag, input logic [31:0] rbase, qbase,
                              input int wr, wq, nr, nq, offr, offq, is);
        int bad = 0;
        check({tag, "_nwr_ref"}, 64'(nwr_r), 64'(nr));
        check({tag, "_nwr_query"}, 64'(nwr_q), 64'(nq));
        check({tag, "_offsets"}, {ref_start_offset, query_start_offset}, 64'({offr[1:0], offq[1:0]}));
        check({tag, "_init_state"}, init_state, 64'(is));
        for (int i = 0; i < nr; i++) if (rb[i] !== memw(rbase + 32'(wr + i))) bad++;
        for (int i = 0; i < nq; i++) if (qb[i] !== memw(qbase + 32'(wq + i))) bad++;
        check({tag, "_bram_words"}, 64'(bad), 0);
    endtask

    task automatic end_tile(input string tag, input logic [15:0] nr, nq, input logic [1:0] ni, input int tc);
        stop = 1'b1;
        ref_next_tile_addr = nr; query_next_tile_addr = nq; next_tile_init_state = ni;
        @(posedge clk);
        #1;
        stop = 1'b0;
        ref_next_tile_addr = 16'hFFFF; query_next_tile_addr = 16'hFFFF; next_tile_init_state = 2'b00;
        @(negedge clk);
        check({tag, "_tile_rst_start"}, {tile_rst, start}, 2'b10);
        check({tag, "_tile_count"}, tile_count, 64'(tc));
        nwr_r = 0; nwr_q = 0;
    endtask

    bit err;

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; stop = 1'b0;
        cfg_ref_base = '0; cfg_query_base = '0; cfg_ref_len = '0; cfg_query_len = '0;
        cfg_marker = '0; cfg_init_state = '0;
        ref_next_tile_addr = '0; query_next_tile_addr = '0; next_tile_init_state = '0;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_ctrl", {busy, start, tile_rst, done, error, mem_rd_req, ref_wr_en, query_wr_en}, 0);
        check("rst_data", {tile_count, init_state, ref_start_offset, query_start_offset, mem_rd_addr}, 0);
        rst = 1'b1;

        // single tile, 16 words each channel
        run_cfg(1000, 5000, 64, 64, 506, 2);
        @(negedge clk);
        check("t1_busy_ready", {busy, cfg_ready}, 2'b10);
        wait_start("t1");
        check_tile("t1", 1000, 5000, 0, 0, 16, 16, 0, 0, 2);
        repeat (5) @(negedge clk);
        check("t1_start_hold", start, 1);
        end_tile("t1", 64, 64, 0, 1);
        wait_done("t1", err);
        check("t1_err", err, 0);
        check("t1_tile_count", tile_count, 1);
        @(negedge clk);
        check("t1_idle", {busy, cfg_ready}, 2'b01);

        // two tiles with unaligned second start
        run_cfg(40000, 60000, 2000, 2000, 506, 1);
        wait_start("t2a");
        check_tile("t2a", 40000, 60000, 0, 0, 127, 127, 0, 0, 1);
        end_tile("t2a", 498, 497, 3, 1);
        wait_start("t2b");
        check_tile("t2b", 40000, 60000, 124, 124, 127, 127, 2, 1, 3);
        end_tile("t2b", 2000, 2000, 0, 2);
        wait_done("t2", err);
        check("t2_err", err, 0);
        check("t2_tile_count", tile_count, 2);

        // random ready and latency
        rnd_ready = 1; lat_min = 1; lat_max = 8;
        run_cfg(20000, 30000, 300, 200, 100, 0);
        wait_start("t3a");
        check_tile("t3a", 20000, 30000, 0, 0, 25, 25, 0, 0, 0);
        end_tile("t3a", 101, 99, 2, 1);
        wait_start("t3b");
        check_tile("t3b", 20000, 30000, 25, 24, 26, 26, 1, 3, 2);
        end_tile("t3b", 150, 150, 1, 2);
        wait_done("t3", err);
        check("t3_err", err, 0);
        check("t3_tile_count", tile_count, 2);
        rnd_ready = 0; lat_max = 1;

        // short ref channel, then zero advance
        run_cfg(50000, 52000, 40, 200, 100, 3);
        wait_start("t4");
        check_tile("t4", 50000, 52000, 0, 0, 10, 25, 0, 0, 3);
        end_tile("t4", 0, 0, 1, 1);
        wait_done("t4", err);
        check("t4_err", err, 1);
        @(negedge clk);
        check("t4_idle", {busy, cfg_ready}, 2'b01);

        // empty query and invalid markers
        req_seen = 0;
        run_cfg(0, 0, 100, 0, 100, 0);
        @(negedge clk);
        check("t5_done", {done, error}, 2'b10);
        check("t5_tile_count", tile_count, 0);
        @(negedge clk);
        check("t5_idle", {busy, cfg_ready}, 2'b01);
        check("t5_no_req", req_seen, 0);
        run_cfg(0, 0, 100, 100, 600, 0);
        @(negedge clk);
        check("t5_m600", {error, busy, cfg_ready}, 3'b101);
        run_cfg(0, 0, 100, 100, 510, 0);
        @(negedge clk);
        check("t5_m510", {error, busy, cfg_ready}, 3'b101);
        run_cfg(0, 0, 100, 100, 0, 0);
        @(negedge clk);
        check("t5_m0", {error, busy, cfg_ready}, 3'b101);
        repeat (3) @(negedge clk);
        check("t5_stay_idle", {busy, req_seen}, 0);

        // reset in the middle of a load
        lat_min = 8; lat_max = 8;
        run_cfg(7000, 9000, 64, 64, 506, 0);
        for (int i = 0; i < 100 && q.size() < 3; i++) @(negedge clk);
        check("t6_pending", 64'(q.size() >= 3), 1);
        rst = 1'b0;
        #1;
        check("t6_cfg_ready", cfg_ready, 1);
        check("t6_ctrl", {busy, start, tile_rst, done, error, mem_rd_req, ref_wr_en, query_wr_en}, 0);
        check("t6_data", {tile_count, init_state, mem_rd_addr}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lat_min = 1; lat_max = 1;
        run_cfg(7000, 9000, 64, 64, 506, 1);
        wait_start("t6");
        check_tile("t6", 7000, 9000, 0, 0, 16, 16, 0, 0, 1);
        end_tile("t6", 100, 64, 0, 1);
        wait_done("t6", err);
        check("t6_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
